// File: rtl/dct_mac_datapath.sv
// Three-stage multiply-accumulate datapath for an 8x8 2-D DCT: cosine lookup,
// centred-pixel product, and a 64-term accumulator with rounding and saturation.
//
// state | meaning
// IDLE  | waiting for the (0,0) term that opens a block
// ACCUM | block open, counting accepted terms toward 64
module dct_mac_datapath #(
  parameter int PIXEL_W = 8,
  parameter int COEF_W  = 12
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Active_MAC,
  input  logic [2:0]               u,
  input  logic [2:0]               v,
  input  logic [2:0]               x,
  input  logic [2:0]               y,
  input  logic [PIXEL_W-1:0]       Pixel_In,
  output logic signed [COEF_W-1:0] Coef_Out,
  output logic                     Coef_Valid,
  output logic [5:0]               Coef_Addr,
  output logic                     Busy,
  output logic                     Seq_Error
);

  localparam int PROD_W = PIXEL_W + 17;
  localparam int ACC_W  = 32;
  localparam logic signed [PIXEL_W:0]  PIX_OFS = (PIXEL_W+1)'(2**(PIXEL_W-1));
  localparam logic signed [ACC_W-1:0]  SAT_MAX = (ACC_W'(1) <<< (COEF_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = ~SAT_MAX;
  localparam logic signed [ACC_W-1:0]  RND     = ACC_W'(8192);

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  // 64*cos(m*pi/16) folded into the first quadrant; row 0 carries the 1/sqrt2 scale
  function automatic logic signed [7:0] cos_rom(input logic [2:0] k, input logic [2:0] n);
    logic [4:0] m;
    logic [4:0] r;
    logic       neg;
    logic [6:0] mag;
    logic signed [7:0] val;
    m   = 5'({n, 1'b1}) * 5'(k);
    neg = 1'b0;
    if (m > 5'd16) m = 5'd0 - m;
    r = m;
    if (m > 5'd8) begin
      r   = 5'd16 - m;
      neg = 1'b1;
    end
    case (r)
      5'd0:    mag = 7'd64;
      5'd1:    mag = 7'd63;
      5'd2:    mag = 7'd59;
      5'd3:    mag = 7'd53;
      5'd4:    mag = 7'd45;
      5'd5:    mag = 7'd36;
      5'd6:    mag = 7'd24;
      5'd7:    mag = 7'd12;
      default: mag = 7'd0;
    endcase
    val = {1'b0, mag};
    if (k == 3'd0) return 8'sd45;
    return neg ? -val : val;
  endfunction

  logic                     s1_valid, s1_first;
  logic [5:0]               s1_uv;
  logic signed [7:0]        s1_tux, s1_tvy;
  logic                     s2_valid, s2_first;
  logic [5:0]               s2_uv;
  logic signed [PROD_W-1:0] s2_prod;

  logic signed [PIXEL_W:0]  pix_c;
  logic signed [PROD_W-1:0] prod_c;

  assign pix_c  = $signed({1'b0, Pixel_In}) - PIX_OFS;
  assign prod_c = PROD_W'(pix_c) * PROD_W'(s1_tux) * PROD_W'(s1_tvy);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_uv    <= '0;
      s1_tux   <= '0;
      s1_tvy   <= '0;
      s2_valid <= 1'b0;
      s2_first <= 1'b0;
      s2_uv    <= '0;
      s2_prod  <= '0;
    end else begin
      s1_valid <= Active_MAC;
      if (Active_MAC) begin
        s1_first <= (x == 3'd0) && (y == 3'd0);
        s1_uv    <= {u, v};
        s1_tux   <= cos_rom(u, x);
        s1_tvy   <= cos_rom(v, y);
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_first <= s1_first;
        s2_uv    <= s1_uv;
        s2_prod  <= prod_c;
      end
    end
  end

  state_t                   state_q, state_d;
  logic [5:0]               cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  prod_ext, sum_c, rnd_c;
  logic signed [COEF_W-1:0] sat_c;
  logic                     do_load, do_add, do_done, err_set;

  assign prod_ext = ACC_W'(s2_prod);
  assign sum_c    = acc_q + prod_ext;
  assign rnd_c    = (sum_c + RND) >>> 14;

  always_comb begin
    sat_c = rnd_c[COEF_W-1:0];
    if (rnd_c > SAT_MAX)      sat_c = SAT_MAX[COEF_W-1:0];
    else if (rnd_c < SAT_MIN) sat_c = SAT_MIN[COEF_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    do_load = 1'b0;
    do_add  = 1'b0;
    do_done = 1'b0;
    err_set = 1'b0;
    if (s2_valid) begin
      case (state_q)
        IDLE: begin
          if (s2_first) begin
            do_load = 1'b1;
            state_d = ACCUM;
          end else begin
            err_set = 1'b1;
          end
        end
        ACCUM: begin
          if (s2_first) begin
            do_load = 1'b1;
            err_set = 1'b1;
          end else if (cnt_q == 6'd63) begin
            do_done = 1'b1;
            state_d = IDLE;
          end else begin
            do_add = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      Coef_Out   <= '0;
      Coef_Valid <= 1'b0;
      Coef_Addr  <= '0;
      Seq_Error  <= 1'b0;
    end else begin
      Coef_Valid <= do_done;
      if (err_set) Seq_Error <= 1'b1;
      if (do_load) begin
        acc_q <= prod_ext;
        cnt_q <= 6'd1;
      end
      if (do_add) begin
        acc_q <= sum_c;
        cnt_q <= cnt_q + 6'd1;
      end
      if (do_done) begin
        acc_q     <= sum_c;
        cnt_q     <= '0;
        Coef_Out  <= sat_c;
        Coef_Addr <= s2_uv;
      end
    end
  end

  assign Busy = (state_q == ACCUM) || s1_valid || s2_valid;

endmodule

// File: tb/tb_dct_mac_datapath.sv
// Directed bench for dct_mac_datapath: constant-pixel blocks with hand-computed
// coefficients, latency, bubbles, resets mid-block and term-sequence errors.
module tb_dct_mac_datapath;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Active_MAC;
  logic [2:0]        u, v, x, y;
  logic [7:0]        Pixel_In;
  logic signed [11:0] Coef_Out;
  logic              Coef_Valid;
  logic [5:0]        Coef_Addr;
  logic              Busy;
  logic              Seq_Error;

  dct_mac_datapath dut (
    .Clock(Clock), .Reset(Reset), .Active_MAC(Active_MAC),
    .u(u), .v(v), .x(x), .y(y), .Pixel_In(Pixel_In),
    .Coef_Out(Coef_Out), .Coef_Valid(Coef_Valid), .Coef_Addr(Coef_Addr),
    .Busy(Busy), .Seq_Error(Seq_Error)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;
  int busy_drops = 0;
  bit busy_watch = 0;
  bit watch_arm = 0;
  logic [7:0] pix_pending = 8'd0;
  int q_cyc[$];
  int q_val[$];
  int q_addr[$];

  always @(posedge Clock) cyc <= cyc + 1;

  always @(negedge Clock)
    if (Coef_Valid) begin
      q_cyc.push_back(cyc);
      q_val.push_back(int'(Coef_Out));
      q_addr.push_back(int'(Coef_Addr));
    end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // image memory answers one cycle after the term's cycle
  task automatic drive_term(input logic [2:0] uu, input logic [2:0] vv,
                            input logic [2:0] xx, input logic [2:0] yy, input logic [7:0] pix);
    @(negedge Clock);
    if (busy_watch && !Busy) busy_drops++;
    Reset = 1'b0;
    Active_MAC = 1'b1;
    u = uu; v = vv; x = xx; y = yy;
    Pixel_In = pix_pending;
    pix_pending = pix;
    last_cyc = cyc;
    if (watch_arm) busy_watch = 1;
  endtask

  task automatic bubble();
    @(negedge Clock);
    Reset = 1'b0;
    Active_MAC = 1'b0;
    Pixel_In = pix_pending;
    pix_pending = 8'd0;
  endtask

  task automatic flush(input int n);
    repeat (n) bubble();
    #1;
  endtask

  task automatic do_reset(input logic act);
    @(negedge Clock);
    Reset = 1'b1;
    Active_MAC = act;
    u = 3'd0; v = 3'd0; x = 3'd0; y = 3'd0;
    Pixel_In = 8'd255;
    pix_pending = 8'd255;
  endtask

  task automatic run_block(input logic [2:0] uu, input logic [2:0] vv, input logic [7:0] pix,
                           input int nterms, input int gap_a, input int gap_b);
    for (int t = 0; t < nterms; t++) begin
      drive_term(uu, vv, t[2:0], t[5:3], pix);
      if (t == gap_a || t == gap_b) repeat (5) bubble();
    end
  endtask

  task automatic clear_q();
    q_cyc.delete();
    q_val.delete();
    q_addr.delete();
  endtask

  task automatic check_one(input string tag, input int exp_val, input int exp_addr);
    check({tag, "_count"}, q_val.size(), 1);
    if (q_val.size() > 0) begin
      check({tag, "_value"}, q_val[$], exp_val);
      check({tag, "_addr"}, q_addr[$], exp_addr);
      check({tag, "_latency"}, q_cyc[$] - last_cyc, 3);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; Active_MAC = 1'b0;
    u = 3'd0; v = 3'd0; x = 3'd0; y = 3'd0; Pixel_In = 8'd0;
    repeat (3) @(negedge Clock);
    check("rst_coef_out", int'(Coef_Out), 0);
    check("rst_coef_valid", int'(Coef_Valid), 0);
    check("rst_coef_addr", int'(Coef_Addr), 0);
    check("rst_busy", int'(Busy), 0);
    check("rst_seq_error", int'(Seq_Error), 0);

    clear_q();
    run_block(3'd0, 3'd0, 8'd255, 64, -1, -1);
    bubble();
    check("dc255_busy_tail", int'(Busy), 1);
    flush(6);
    check_one("dc255", 1005, 0);
    check("dc255_busy_idle", int'(Busy), 0);
    check("dc255_hold", int'(Coef_Out), 1005);
    check("dc255_valid_low", int'(Coef_Valid), 0);

    clear_q();
    run_block(3'd5, 3'd6, 8'd128, 64, -1, -1);
    flush(6);
    check_one("mid128", 0, 46);

    clear_q();
    run_block(3'd0, 3'd0, 8'd0, 64, -1, -1);
    flush(6);
    check_one("dc0", -1012, 0);

    clear_q();
    run_block(3'd1, 3'd0, 8'd255, 64, -1, -1);
    flush(6);
    check_one("u1_255", 0, 8);

    clear_q();
    run_block(3'd0, 3'd0, 8'd255, 64, 9, 39);
    flush(6);
    check_one("gaps", 1005, 0);
    check("gaps_seq_error", int'(Seq_Error), 0);

    clear_q();
    run_block(3'd0, 3'd0, 8'd255, 30, -1, -1);
    do_reset(1'b1);
    run_block(3'd2, 3'd3, 8'd255, 64, -1, -1);
    flush(6);
    check_one("rst_mid", 0, 19);
    check("rst_mid_seq_error", int'(Seq_Error), 0);

    clear_q();
    do_reset(1'b0);
    drive_term(3'd0, 3'd0, 3'd3, 3'd0, 8'd255);
    flush(6);
    check("idle_err_count", q_val.size(), 0);
    check("idle_err_flag", int'(Seq_Error), 1);
    check("idle_err_busy", int'(Busy), 0);

    clear_q();
    do_reset(1'b0);
    bubble();
    #1;
    check("reset_clears_err", int'(Seq_Error), 0);
    run_block(3'd0, 3'd0, 8'd255, 30, -1, -1);
    run_block(3'd0, 3'd0, 8'd255, 64, -1, -1);
    flush(6);
    check_one("restart", 1005, 0);
    check("restart_err", int'(Seq_Error), 1);
    flush(10);
    check("restart_err_sticky", int'(Seq_Error), 1);

    clear_q();
    do_reset(1'b0);
    bubble();
    busy_drops = 0;
    watch_arm = 1;
    run_block(3'd0, 3'd0, 8'd255, 64, -1, -1);
    run_block(3'd1, 3'd0, 8'd255, 64, -1, -1);
    watch_arm = 0;
    busy_watch = 0;
    bubble();
    check("b2b_busy_tail", int'(Busy), 1);
    flush(6);
    check("b2b_count", q_val.size(), 2);
    if (q_val.size() == 2) begin
      check("b2b_val0", q_val[0], 1005);
      check("b2b_val1", q_val[1], 0);
      check("b2b_addr1", q_addr[1], 8);
      check("b2b_spacing", q_cyc[1] - q_cyc[0], 64);
      check("b2b_latency", q_cyc[1] - last_cyc, 3);
    end
    check("b2b_busy_drops", busy_drops, 0);
    check("b2b_seq_error", int'(Seq_Error), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
